// File: rtl/fetch_queue_if.sv
// ============================================================
// fetch_queue_if : fetch/decode/imem handshake bundle for fetch_queue
// Revision: 1.0
// ============================================================
`default_nettype none

interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     in_redirect;
  logic [63:0]              in_redirect_pc;
  logic                     in_halt;
  logic                     out_imem_req;
  logic [63:0]              out_imem_addr;
  logic                     in_imem_valid;
  logic [31:0]              in_imem_data;
  logic                     out_valid;
  logic [31:0]              out_insnbits;
  logic [63:0]              out_pc;
  logic                     in_dec_ready;
  logic [$clog2(DEPTH):0]   out_count;

  modport slave (
    input  in_redirect, in_redirect_pc, in_halt, in_imem_valid, in_imem_data, in_dec_ready,
    output out_imem_req, out_imem_addr, out_valid, out_insnbits, out_pc, out_count
  );

  modport master (
    output in_redirect, in_redirect_pc, in_halt, in_imem_valid, in_imem_data, in_dec_ready,
    input  out_imem_req, out_imem_addr, out_valid, out_insnbits, out_pc, out_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================
// fetch_queue : fetch PC generator and instruction buffer feeding decode
// Revision: 1.0
// ============================================================
`default_nettype none

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          in_clk,
  input  logic          in_rst,
  fetch_queue_if.slave  bus
);
  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;

  logic [63:0]     pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            inflight_q, inflight_d;
  logic [63:0]     ipc_q, ipc_d;
  logic            drop_q, drop_d;
  logic [C_AW-1:0] head_q, head_d;
  logic [C_AW-1:0] tail_q, tail_d;
  logic [C_CW-1:0] count_q, count_d;

  logic [31:0]     insn_mem [DEPTH];
  logic [63:0]     pc_mem   [DEPTH];

  logic [C_CW:0]   w_occ;
  logic            w_req;
  logic            w_enq;
  logic            w_deq;

  // Credit includes the in-flight fetch so a returning response always has a slot.
  assign w_occ = {1'b0, count_q} + {{C_CW{1'b0}}, inflight_q};
  assign w_req = !halted_q && !bus.in_redirect && (w_occ < (C_CW+1)'(DEPTH));
  assign w_enq = inflight_q && bus.in_imem_valid && !drop_q && !bus.in_redirect;
  assign w_deq = (count_q != '0) && bus.in_dec_ready;

  assign bus.out_imem_req  = w_req;
  assign bus.out_imem_addr = pc_q;
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_insnbits  = insn_mem[head_q];
  assign bus.out_pc        = pc_mem[head_q];
  assign bus.out_count     = count_q;

  always_comb begin
    pc_d       = pc_q;
    halted_d   = halted_q;
    inflight_d = inflight_q;
    ipc_d      = ipc_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.in_redirect) begin
      pc_d       = bus.in_redirect_pc;
      halted_d   = 1'b0;
      drop_d     = inflight_q;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      drop_d = 1'b0;
      if (bus.in_halt) halted_d = 1'b1;
      if (w_req) begin
        pc_d       = pc_q + 64'd4;
        ipc_d      = pc_q;
        inflight_d = 1'b1;
      end else begin
        inflight_d = 1'b0;
      end
      if (w_deq) head_d = head_q + C_AW'(1);
      if (w_enq) tail_d = tail_q + C_AW'(1);
      case ({w_enq, w_deq})
        2'b10:   count_d = count_q + C_CW'(1);
        2'b01:   count_d = count_q - C_CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      pc_q       <= RESET_PC;
      halted_q   <= 1'b0;
      inflight_q <= 1'b0;
      ipc_q      <= RESET_PC;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      inflight_q <= inflight_d;
      ipc_q      <= ipc_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst && w_enq) begin
      insn_mem[tail_q] <= bus.in_imem_data;
      pc_mem[tail_q]   <= ipc_q;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================
// tb_fetch_queue : directed + random checks of fetch_queue (DEPTH 4, 2, 8)
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_fetch_queue;
  localparam logic [63:0] C_RST_PC = 64'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(4)) bus4 ();
  fetch_queue_if #(.DEPTH(2)) bus2 ();
  fetch_queue_if #(.DEPTH(8)) bus8 ();

  fetch_queue #(.DEPTH(4), .RESET_PC(C_RST_PC)) u_dut4 (.in_clk(clk), .in_rst(rst), .bus(bus4.slave));
  fetch_queue #(.DEPTH(2), .RESET_PC(C_RST_PC)) u_dut2 (.in_clk(clk), .in_rst(rst), .bus(bus2.slave));
  fetch_queue #(.DEPTH(8), .RESET_PC(C_RST_PC)) u_dut8 (.in_clk(clk), .in_rst(rst), .bus(bus8.slave));

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[31:2], 2'b01} ^ a[63:32] ^ 32'h5EED_0000;
  endfunction

  // Instruction memory: fixed one-cycle response to every request.
  always @(posedge clk) begin
    bus4.in_imem_valid <= bus4.out_imem_req && !rst;
    bus4.in_imem_data  <= mem_word(bus4.out_imem_addr);
    bus2.in_imem_valid <= bus2.out_imem_req && !rst;
    bus2.in_imem_data  <= mem_word(bus2.out_imem_addr);
    bus8.in_imem_valid <= bus8.out_imem_req && !rst;
    bus8.in_imem_data  <= mem_word(bus8.out_imem_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference for the DEPTH=4 instance: fetch state plus a queue of {insn, pc}.
  logic [63:0] m_pc = C_RST_PC;
  logic        m_halted = 1'b0;
  logic        m_inflight = 1'b0;
  logic [63:0] m_ipc = C_RST_PC;
  logic        m_drop = 1'b0;
  logic [95:0] mq [$];

  // Stream scoreboards for the DEPTH=2 / DEPTH=8 instances.
  logic [63:0] sb_exp [2];
  logic        sb_ok  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_step(input int k, input logic v, input logic rdy, input logic rd,
                         input logic [63:0] rpc, input logic [63:0] pc,
                         input logic [31:0] insn, input logic [63:0] cnt, input int depth);
    if (v && rdy) begin
      chk("sb_insn", 64'(insn), 64'(mem_word(pc)));
      if (sb_ok[k]) chk("sb_pc_contig", pc, sb_exp[k]);
      sb_exp[k] = pc + 64'd4;
      sb_ok[k]  = 1'b1;
    end
    chk("sb_count_le_depth", 64'(cnt <= 64'(depth)), 64'd1);
    if (rd) begin
      sb_exp[k] = rpc;
      sb_ok[k]  = 1'b1;
    end
  endtask

  task automatic drive(input logic rdy, input logic rd, input logic [63:0] rpc, input logic h);
    bus4.in_dec_ready = rdy; bus4.in_redirect = rd; bus4.in_redirect_pc = rpc; bus4.in_halt = h;
    bus2.in_dec_ready = rdy; bus2.in_redirect = rd; bus2.in_redirect_pc = rpc; bus2.in_halt = h;
    bus8.in_dec_ready = rdy; bus8.in_redirect = rd; bus8.in_redirect_pc = rpc; bus8.in_halt = h;
  endtask

  // One clock cycle: apply inputs, compare outputs, advance the reference.
  task automatic step(input logic r, input logic rdy, input logic rd,
                      input logic [63:0] rpc, input logic h);
    logic        e_req;
    logic [95:0] hd;
    rst = r;
    drive(rdy, rd, rpc, h);
    #1;
    if (r) begin
      m_pc = C_RST_PC; m_halted = 1'b0; m_inflight = 1'b0; m_drop = 1'b0;
      mq.delete();
      for (int k = 0; k < 2; k++) begin sb_exp[k] = C_RST_PC; sb_ok[k] = 1'b1; end
    end else begin
      e_req = !m_halted && !rd && ((mq.size() + int'(m_inflight)) < 4);
      chk("imem_req", 64'(bus4.out_imem_req), 64'(e_req));
      chk("imem_addr", bus4.out_imem_addr, m_pc);
      chk("count", 64'(bus4.out_count), 64'(mq.size()));
      chk("valid", 64'(bus4.out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        hd = mq[0];
        chk("head_pc", bus4.out_pc, hd[63:0]);
        chk("head_insn", 64'(bus4.out_insnbits), 64'(hd[95:64]));
      end
      sb_step(0, bus2.out_valid, rdy, rd, rpc, bus2.out_pc, bus2.out_insnbits, 64'(bus2.out_count), 2);
      sb_step(1, bus8.out_valid, rdy, rd, rpc, bus8.out_pc, bus8.out_insnbits, 64'(bus8.out_count), 8);
      if (rd) begin
        m_pc = rpc; mq.delete(); m_halted = 1'b0;
        m_drop = m_inflight; m_inflight = 1'b0;
      end else begin
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (m_inflight && !m_drop) mq.push_back({mem_word(m_ipc), m_ipc});
        if (e_req) begin
          m_ipc = m_pc; m_pc = m_pc + 64'd4; m_inflight = 1'b1;
        end else begin
          m_inflight = 1'b0;
        end
        m_drop = 1'b0;
        if (h) m_halted = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic       r, rdy, rd, h;
    logic [63:0] rpc;
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Reset release with decode stalled: queue fills, head stays at RESET_PC.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("sat_count", 64'(bus4.out_count), 64'd4);
    chk("sat_head", bus4.out_pc, C_RST_PC);
    chk("sat_req_off", 64'(bus4.out_imem_req), 64'd0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    chk("steady_count_le2", 64'(bus4.out_count <= 3'd2), 64'd1);

    // Redirect with three queued and one fetch in flight.
    for (int i = 0; i < 10 && !(mq.size() == 3 && m_inflight); i++) step(0, 0, 0, 0, 0);
    chk("redir_setup_count", 64'(bus4.out_count), 64'd3);
    step(0, 0, 1, 64'h2000, 0);
    chk("redir_t1_valid", 64'(bus4.out_valid), 64'd0);
    step(0, 1, 0, 0, 0);
    chk("redir_t2_valid", 64'(bus4.out_valid), 64'd0);
    step(0, 1, 0, 0, 0);
    chk("redir_t3_pc", bus4.out_pc, 64'h2000);
    step(0, 1, 0, 0, 0);
    chk("redir_t4_pc", bus4.out_pc, 64'h2004);

    // Halt: drain, then no requests until the next redirect.
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 25; i++) step(0, 1, 0, 0, 0);
    chk("halt_req_off", 64'(bus4.out_imem_req), 64'd0);
    chk("halt_drained", 64'(bus4.out_count), 64'd0);
    step(0, 1, 1, 64'h3000, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);

    // Redirect and halt together: redirect wins, fetching continues.
    step(0, 1, 1, 64'h4000, 1);
    step(0, 1, 0, 0, 0);
    chk("redir_halt_req", 64'(bus4.out_imem_req), 64'd1);
    chk("redir_halt_addr", bus4.out_imem_addr, 64'h4004);

    // PC wrap at the top of the address space.
    step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);

    // Reset while full.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", 64'(bus4.out_valid), 64'd0);
    chk("rst_count", 64'(bus4.out_count), 64'd0);
    chk("rst_addr", bus4.out_imem_addr, C_RST_PC);
    chk("rst_req", 64'(bus4.out_imem_req), 64'd1);

    // Random stress across all three depths.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 499) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 29) == 0);
      h   = ($urandom_range(0, 49) == 0);
      rpc = {$urandom, $urandom} & ~64'h3;
      step(r, rdy, rd, rpc, h);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
